// File: rtl/ram_block_reader_if.sv
// Request, RAM read port and output stream bundle for the burst read engine.
interface ram_block_reader_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 8
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] burst_len;
  logic          swap_bytes;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, base_addr, burst_len, swap_bytes, ram_rdata, out_ready,
    output ram_rd_en, ram_addr, out_data, out_valid, out_last, busy, done
  );

  modport slave (
    output start, base_addr, burst_len, swap_bytes, ram_rdata, out_ready,
    input  ram_rd_en, ram_addr, out_data, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/ram_block_reader.sv
// Burst read engine: reads consecutive RAM words and streams them out
// through a small shift FIFO whose head register drives the output port.
module ram_block_reader #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 8,
  parameter int unsigned FD = 4
) (
  input  logic               clk,
  input  logic               rst,
  ram_block_reader_if.master bus
);
  localparam int unsigned CW = $clog2(FD + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e        state_q, state_d;
  logic          rd_en_q, rd_en_d;
  logic          rd_last_q, rd_last_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [AW-1:0] nxt_addr_q, nxt_addr_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic          swap_q, swap_d;
  logic          resp_q, resp_d;
  logic          resp_last_q, resp_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] data_q [FD];
  logic [DW-1:0] data_d [FD];
  logic          last_q [FD];
  logic          last_d [FD];
  logic          vld_q  [FD];
  logic          vld_d  [FD];

  logic          pop;
  logic          room;
  logic [CW-1:0] count_s;
  logic [CW:0]   occ;
  logic [DW-1:0] push_word;

  // Next-state, read issue and FIFO shift/insert logic.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    rd_last_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    nxt_addr_d  = nxt_addr_q;
    remaining_d = remaining_q;
    swap_d      = swap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    resp_d      = rd_en_q;
    resp_last_d = rd_last_q;
    data_d      = data_q;
    last_d      = last_q;
    vld_d       = vld_q;

    pop       = vld_q[0] & bus.out_ready;
    push_word = swap_q ? {bus.ram_rdata[DW/2-1:0], bus.ram_rdata[DW-1:DW/2]}
                       : bus.ram_rdata;

    // Pop shifts every entry toward the head.
    if (pop) begin
      for (int i = 0; i < int'(FD) - 1; i++) begin
        data_d[i] = data_q[i+1];
        last_d[i] = last_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      data_d[FD-1] = '0;
      last_d[FD-1] = 1'b0;
      vld_d[FD-1]  = 1'b0;
    end
    count_s = count_q - CW'(pop);

    // Returning RAM word lands in the first free slot after the pop.
    if (resp_q) begin
      for (int i = 0; i < int'(FD); i++) begin
        if (CW'(i) == count_s) begin
          data_d[i] = push_word;
          last_d[i] = resp_last_q;
          vld_d[i]  = 1'b1;
        end
      end
    end
    count_d = count_s + CW'(resp_q);

    // A new read needs a slot beyond stored words and the read now on the bus.
    occ  = (CW+1)'(count_d) + (CW+1)'(rd_en_q);
    room = occ < (CW+1)'(FD);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_len != '0) begin
            state_d     = READ;
            busy_d      = 1'b1;
            rd_en_d     = 1'b1;
            rd_last_d   = (bus.burst_len == LW'(1));
            ram_addr_d  = bus.base_addr;
            nxt_addr_d  = bus.base_addr + AW'(1);
            remaining_d = bus.burst_len - LW'(1);
            swap_d      = bus.swap_bytes;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (remaining_q == '0) begin
          state_d = DRAIN;
        end else if (room) begin
          rd_en_d     = 1'b1;
          rd_last_d   = (remaining_q == LW'(1));
          ram_addr_d  = nxt_addr_q;
          nxt_addr_d  = nxt_addr_q + AW'(1);
          remaining_d = remaining_q - LW'(1);
        end
      end
      DRAIN: begin
        if (pop && last_q[0]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_last_q   <= 1'b0;
      ram_addr_q  <= '0;
      nxt_addr_q  <= '0;
      remaining_q <= '0;
      swap_q      <= 1'b0;
      resp_q      <= 1'b0;
      resp_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < int'(FD); i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_last_q   <= rd_last_d;
      ram_addr_q  <= ram_addr_d;
      nxt_addr_q  <= nxt_addr_d;
      remaining_q <= remaining_d;
      swap_q      <= swap_d;
      resp_q      <= resp_d;
      resp_last_q <= resp_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      data_q      <= data_d;
      last_q      <= last_d;
      vld_q       <= vld_d;
    end
  end

  assign bus.ram_rd_en = rd_en_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.out_data  = data_q[0];
  assign bus.out_valid = vld_q[0];
  assign bus.out_last  = last_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
